// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants for the writeback exception/interrupt commit controller:
// LoongArch Ecodes, exception-vector bit positions and FSM state encoding.
package exc_commit_ctrl_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    localparam logic [8:0] ESUB_NONE  = 9'h000;

    // wb_exc_vec = {ale, brk, sys, ipe, ine, adef}
    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_IPE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_ALE  = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Priority encoder: interrupt > adef > ine > ipe > sys > brk > ale > ertn.
// Purely combinational; the caller gates the result with wb_valid and state.
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  logic [5:0] exc_vec,
    input  logic       has_int,
    input  logic       is_ertn,
    output logic       take_ex,
    output logic       take_ertn,
    output logic [5:0] ecode,
    output logic [8:0] esubcode
);

    always_comb begin
        take_ex   = 1'b1;
        take_ertn = 1'b0;
        ecode     = ECODE_INT;
        esubcode  = ESUB_NONE;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (exc_vec[EXC_ADEF]) begin
            ecode = ECODE_ADEF;
        end else if (exc_vec[EXC_INE]) begin
            ecode = ECODE_INE;
        end else if (exc_vec[EXC_IPE]) begin
            ecode = ECODE_IPE;
        end else if (exc_vec[EXC_SYS]) begin
            ecode = ECODE_SYS;
        end else if (exc_vec[EXC_BRK]) begin
            ecode = ECODE_BRK;
        end else if (exc_vec[EXC_ALE]) begin
            ecode = ECODE_ALE;
        end else begin
            take_ex   = 1'b0;
            take_ertn = is_ertn;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback exception/interrupt/ertn commit sequencer with redirect handshake
// and drain window. Optional BADV output path: define EXC_COMMIT_CTRL_BADV_EN.
//
// state       | meaning
// ST_IDLE     | watching WB for interrupt/exception/ertn
// ST_REDIRECT | holding redirect_valid/redirect_pc until pre-IF accepts
// ST_DRAIN    | stale WB instructions are killed, no new events taken
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_exc_vec,
    input  logic        wb_is_ertn,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    input  logic        fetch_ready,
`ifdef EXC_COMMIT_CTRL_BADV_EN
    input  logic [31:0] wb_vaddr,
    output logic        csr_badv_we,
    output logic [31:0] csr_badv,
`endif
    output logic        csr_wb_ex,
    output logic [5:0]  csr_wb_ecode,
    output logic [8:0]  csr_wb_esubcode,
    output logic [31:0] csr_wb_pc,
    output logic        csr_ertn_flush,
    output logic        commit_kill,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT =
        CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] drain_cnt;

    logic       take_ex;
    logic       take_ertn;
    logic [5:0] enc_ecode;
    logic [8:0] enc_esub;
    logic       ev_en;
    logic       ev_ex;
    logic       ev_ertn;

    exc_prio_enc u_prio_enc (
        .exc_vec   (wb_exc_vec),
        .has_int   (has_int),
        .is_ertn   (wb_is_ertn),
        .take_ex   (take_ex),
        .take_ertn (take_ertn),
        .ecode     (enc_ecode),
        .esubcode  (enc_esub)
    );

    assign ev_en   = (state == ST_IDLE) && wb_valid;
    assign ev_ex   = ev_en && take_ex;
    assign ev_ertn = ev_en && take_ertn;

    // Event-cycle outputs are combinational so the CSR commits in the same WB cycle.
    assign csr_wb_ex       = ev_ex;
    assign csr_wb_ecode    = ev_ex ? enc_ecode : 6'h00;
    assign csr_wb_esubcode = ev_ex ? enc_esub  : 9'h000;
    assign csr_wb_pc       = ev_ex ? wb_pc     : 32'h0;
    assign csr_ertn_flush  = ev_ertn;
    assign commit_kill     = ev_ex || ((state == ST_DRAIN) && wb_valid);
    assign pipe_flush      = ev_ex || ev_ertn || (state == ST_REDIRECT);

`ifdef EXC_COMMIT_CTRL_BADV_EN
    always_comb begin
        csr_badv_we = 1'b0;
        csr_badv    = 32'h0;
        if (ev_ex && enc_ecode == ECODE_ADEF) begin
            csr_badv_we = 1'b1;
            csr_badv    = wb_pc;
        end else if (ev_ex && enc_ecode == ECODE_ALE) begin
            csr_badv_we = 1'b1;
            csr_badv    = wb_vaddr;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            drain_cnt      <= '0;
            redirect_pc    <= 32'h0;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev_ex || ev_ertn) begin
                        redirect_pc    <= ev_ex ? ex_entry : ertn_entry;
                        redirect_valid <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_ready) begin
                        redirect_valid <= 1'b0;
                        if (DRAIN_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            drain_cnt <= DRAIN_INIT;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: stimulus queues expected per-cycle
// output snapshots, a negedge monitor pops and compares them.
module tb_exc_commit_ctrl;

    typedef struct packed {
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc;
        logic        ertn;
        logic        kill;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic        busy;
        logic        badv_we;
        logic [31:0] badv;
    } out_t;

    typedef struct {
        int    cyc;
        string name;
        out_t  exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [5:0]  wb_exc_vec;
    logic        wb_is_ertn;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        fetch_ready;
    logic [31:0] wb_vaddr;
    logic        csr_badv_we;
    logic [31:0] csr_badv;
    logic        csr_wb_ex;
    logic [5:0]  csr_wb_ecode;
    logic [8:0]  csr_wb_esubcode;
    logic [31:0] csr_wb_pc;
    logic        csr_ertn_flush;
    logic        commit_kill;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    sb_item_t sb[$];
    logic [31:0] last_rpc;

    exc_commit_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb_valid        (wb_valid),
        .wb_pc           (wb_pc),
        .wb_exc_vec      (wb_exc_vec),
        .wb_is_ertn      (wb_is_ertn),
        .has_int         (has_int),
        .ex_entry        (ex_entry),
        .ertn_entry      (ertn_entry),
        .fetch_ready     (fetch_ready),
`ifdef EXC_COMMIT_CTRL_BADV_EN
        .wb_vaddr        (wb_vaddr),
        .csr_badv_we     (csr_badv_we),
        .csr_badv        (csr_badv),
`endif
        .csr_wb_ex       (csr_wb_ex),
        .csr_wb_ecode    (csr_wb_ecode),
        .csr_wb_esubcode (csr_wb_esubcode),
        .csr_wb_pc       (csr_wb_pc),
        .csr_ertn_flush  (csr_ertn_flush),
        .commit_kill     (commit_kill),
        .pipe_flush      (pipe_flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .busy            (busy)
    );

`ifndef EXC_COMMIT_CTRL_BADV_EN
    assign csr_badv_we = 1'b0;
    assign csr_badv    = 32'h0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic out_t snapshot();
        out_t a;
        a.wb_ex   = csr_wb_ex;
        a.ecode   = csr_wb_ecode;
        a.esub    = csr_wb_esubcode;
        a.pc      = csr_wb_pc;
        a.ertn    = csr_ertn_flush;
        a.kill    = commit_kill;
        a.flush   = pipe_flush;
        a.rv      = redirect_valid;
        a.rpc     = redirect_pc;
        a.busy    = busy;
        a.badv_we = csr_badv_we;
        a.badv    = csr_badv;
        return a;
    endfunction

    // Monitor: compares every snapshot scheduled for the current cycle.
    always @(negedge clk) begin
        sb_item_t it;
        out_t     act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = snapshot();
            total = total + 1;
            if (it.cyc != cyc || act !== it.exp) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d/%0d got=%h want=%h", it.name, cyc, it.cyc, act, it.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input out_t e);
        sb_item_t it;
        it.cyc  = cyc;
        it.name = nm;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic clear_wb();
        wb_valid   = 1'b0;
        wb_exc_vec = 6'b0;
        wb_is_ertn = 1'b0;
        has_int    = 1'b0;
    endtask

    // Drives one IDLE-cycle exception and queues its expected commit outputs.
    task automatic fire_ex(input string nm, input logic hi, input logic [5:0] vec,
                           input logic ertn, input logic [31:0] pc,
                           input logic [5:0] code);
        out_t e;
        step();
        wb_valid = 1'b1; has_int = hi; wb_exc_vec = vec; wb_is_ertn = ertn; wb_pc = pc;
        e = '0;
        e.wb_ex = 1'b1; e.ecode = code; e.pc = pc; e.kill = 1'b1; e.flush = 1'b1;
        e.rpc = last_rpc;
`ifdef EXC_COMMIT_CTRL_BADV_EN
        if (code == 6'h08) begin e.badv_we = 1'b1; e.badv = pc;       end
        if (code == 6'h09) begin e.badv_we = 1'b1; e.badv = wb_vaddr; end
`endif
        push(nm, e);
    endtask

    // REDIRECT accepted at once, two DRAIN cycles, then back in IDLE.
    task automatic finish_redirect(input string nm, input logic [31:0] tgt);
        out_t e;
        step();
        clear_wb();
        fetch_ready = 1'b1;
        e = '0; e.rv = 1'b1; e.rpc = tgt; e.flush = 1'b1; e.busy = 1'b1;
        push({nm, "_redir"}, e);
        step();
        fetch_ready = 1'b0;
        e = '0; e.rpc = tgt; e.busy = 1'b1;
        push({nm, "_drain0"}, e);
        step();
        push({nm, "_drain1"}, e);
        step();
        e.busy = 1'b0;
        push({nm, "_idle"}, e);
        last_rpc = tgt;
    endtask

    typedef struct {
        logic [5:0] vec;
        logic [5:0] code;
    } prio_vec_t;

    initial begin
        out_t      e;
        prio_vec_t pv[5];
        reset = 1'b1; wb_pc = 32'h0; ex_entry = 32'h1c008000; ertn_entry = 32'h0;
        fetch_ready = 1'b0; wb_vaddr = 32'h0; last_rpc = 32'h0;
        clear_wb();
        step();
        step();
        e = '0;
        push("reset_state", e);
        step();
        reset = 1'b0;

        // Case 1: sys
        fire_ex("c1_sys", 1'b0, 6'b001000, 1'b0, 32'h1c000100, 6'h0B);
        finish_redirect("c1", 32'h1c008000);

        // Case 2: interrupt beats adef
        fire_ex("c2_int_adef", 1'b1, 6'b000001, 1'b0, 32'h1c000200, 6'h00);
        finish_redirect("c2", 32'h1c008000);

        // Priority table walk
        pv[0] = '{6'b100001, 6'h08};
        pv[1] = '{6'b001010, 6'h0D};
        pv[2] = '{6'b001100, 6'h0E};
        pv[3] = '{6'b110000, 6'h0C};
        pv[4] = '{6'b100000, 6'h09};
        for (int i = 0; i < 5; i++) begin
            ex_entry = 32'h1c009000 + 32'(i * 16);
            fire_ex($sformatf("prio%0d", i), 1'b0, pv[i].vec, 1'b0, 32'h1c000300 + 32'(i * 4), pv[i].code);
            finish_redirect($sformatf("prio%0d", i), 32'h1c009000 + 32'(i * 16));
        end
        ex_entry = 32'h1c008000;

        // Exception outranks a simultaneous ertn
        fire_ex("ertn_vs_brk", 1'b0, 6'b010000, 1'b1, 32'h1c000400, 6'h0C);
        finish_redirect("ertn_vs_brk", 32'h1c008000);

        // Case 3: ertn
        ertn_entry = 32'h1c000204;
        step();
        wb_valid = 1'b1; wb_is_ertn = 1'b1; wb_pc = 32'h1c000500;
        e = '0; e.ertn = 1'b1; e.flush = 1'b1; e.rpc = last_rpc;
        push("c3_ertn", e);
        finish_redirect("c3", 32'h1c000204);

        // Interrupt without a WB instruction waits
        step();
        has_int = 1'b1;
        e = '0; e.rpc = last_rpc;
        push("int_no_wb", e);
        fire_ex("int_with_wb", 1'b1, 6'b0, 1'b0, 32'h1c000600, 6'h00);
        finish_redirect("int_wb", 32'h1c008000);

        // Case 4: stalled redirect, then drain kills a brk
        fire_ex("c4_sys", 1'b0, 6'b001000, 1'b0, 32'h1c000700, 6'h0B);
        for (int i = 0; i < 3; i++) begin
            step();
            clear_wb();
            ex_entry = 32'hdead0000 + 32'(i);
            e = '0; e.rv = 1'b1; e.rpc = 32'h1c008000; e.flush = 1'b1; e.busy = 1'b1;
            push($sformatf("c4_hold%0d", i), e);
        end
        step();
        fetch_ready = 1'b1;
        push("c4_accept", e);
        for (int i = 0; i < 2; i++) begin
            step();
            fetch_ready = 1'b0;
            wb_valid = 1'b1; wb_exc_vec = 6'b010000;
            e = '0; e.kill = 1'b1; e.rpc = 32'h1c008000; e.busy = 1'b1;
            push($sformatf("c4_drain%0d", i), e);
        end
        step();
        clear_wb();
        e = '0; e.rpc = 32'h1c008000;
        push("c4_idle", e);
        ex_entry = 32'h1c008000;
        last_rpc = 32'h1c008000;

        // Case 5: reset in REDIRECT
        fire_ex("c5_brk", 1'b0, 6'b010000, 1'b0, 32'h1c000800, 6'h0C);
        step();
        clear_wb();
        reset = 1'b1;
        e = '0; e.rv = 1'b1; e.rpc = 32'h1c008000; e.flush = 1'b1; e.busy = 1'b1;
        push("c5_redir", e);
        step();
        reset = 1'b0;
        e = '0;
        push("c5_after_reset", e);
        last_rpc = 32'h0;

`ifdef EXC_COMMIT_CTRL_BADV_EN
        // Case 6: ale loads BADV from the data address
        wb_vaddr = 32'h1c0000a3;
        fire_ex("c6_ale", 1'b0, 6'b100000, 1'b0, 32'h1c000900, 6'h09);
        finish_redirect("c6", 32'h1c008000);
`endif

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            bad = bad + 1;
            total = total + 1;
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
